// File: rtl/calc1_if.sv
// Per-port request/response bundle for the calc1 calculator.
// Bit 0 is the MSB of every field.
interface calc1_if;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RESP_W = 2;

    logic [0:CMD_W-1]  cmd;
    logic [0:DATA_W-1] data;
    logic [0:DATA_W-1] out_data;
    logic [0:RESP_W-1] out_resp;

    // Requester side drives the request, samples the response
    modport master (
        output cmd,
        output data,
        input  out_data,
        input  out_resp
    );

    // Calculator side samples the request, drives the response
    modport slave (
        input  cmd,
        input  data,
        output out_data,
        output out_resp
    );
endinterface

// File: rtl/calc1.sv
// calc1: four independent 32-bit integer calculator ports.
// Each port takes cmd+op1 on one edge and op2 on the next, then presents a
// registered response for exactly one cycle.
module calc1 (
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    input  logic        c_clk,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    input  logic [1:7]  reset
);
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned CMD_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RESP_W    = 2;
    localparam int unsigned SHAMT_W   = 5;

    localparam logic [0:CMD_W-1] CMD_NOP = CMD_W'(0);
    localparam logic [0:CMD_W-1] CMD_ADD = CMD_W'(1);
    localparam logic [0:CMD_W-1] CMD_SUB = CMD_W'(2);
    localparam logic [0:CMD_W-1] CMD_SHL = CMD_W'(5);
    localparam logic [0:CMD_W-1] CMD_SHR = CMD_W'(6);

    localparam logic [0:RESP_W-1] RESP_NONE = RESP_W'(0);
    localparam logic [0:RESP_W-1] RESP_OK   = RESP_W'(1);
    localparam logic [0:RESP_W-1] RESP_ERR  = RESP_W'(2);

    typedef enum logic {
        ST_IDLE,
        ST_OP2
    } state_t;

    // Any reset bit resets the whole block
    logic w_rst;
    assign w_rst = |reset;

    logic [0:CMD_W-1]  w_cmd      [1:NUM_PORTS];
    logic [0:DATA_W-1] w_data     [1:NUM_PORTS];
    logic [0:DATA_W-1] w_out_data [1:NUM_PORTS];
    logic [0:RESP_W-1] w_out_resp [1:NUM_PORTS];

    assign w_cmd[1]  = req1_cmd_in;
    assign w_cmd[2]  = req2_cmd_in;
    assign w_cmd[3]  = req3_cmd_in;
    assign w_cmd[4]  = req4_cmd_in;
    assign w_data[1] = req1_data_in;
    assign w_data[2] = req2_data_in;
    assign w_data[3] = req3_data_in;
    assign w_data[4] = req4_data_in;

    assign out_data1 = w_out_data[1];
    assign out_data2 = w_out_data[2];
    assign out_data3 = w_out_data[3];
    assign out_data4 = w_out_data[4];
    assign out_resp1 = w_out_resp[1];
    assign out_resp2 = w_out_resp[2];
    assign out_resp3 = w_out_resp[3];
    assign out_resp4 = w_out_resp[4];

    for (genvar n = 1; n <= 4; n++) begin : g_port
        calc1_if u_bus ();

        state_t            r_state;
        state_t            w_state_nxt;
        logic [0:CMD_W-1]  r_cmd;
        logic [0:CMD_W-1]  w_cmd_nxt;
        logic [0:DATA_W-1] r_op1;
        logic [0:DATA_W-1] w_op1_nxt;
        logic [0:RESP_W-1] r_resp;
        logic [0:RESP_W-1] w_resp_nxt;
        logic [0:DATA_W-1] r_data;
        logic [0:DATA_W-1] w_data_nxt;
        logic [0:RESP_W-1] w_alu_resp;
        logic [0:DATA_W-1] w_alu_data;
        logic [0:DATA_W]   w_sum;

        assign u_bus.cmd      = w_cmd[n];
        assign u_bus.data     = w_data[n];
        assign u_bus.out_resp = r_resp;
        assign u_bus.out_data = r_data;
        assign w_out_resp[n]  = u_bus.out_resp;
        assign w_out_data[n]  = u_bus.out_data;

        // Extra MSB of the sum is the carry out of bit 0
        assign w_sum = {1'b0, r_op1} + {1'b0, u_bus.data};

        // ALU: latched command and op1 against the op2 currently on the bus
        always_comb begin
            w_alu_resp = RESP_ERR;
            w_alu_data = '0;
            case (r_cmd)
                CMD_ADD: begin
                    if (!w_sum[0]) begin
                        w_alu_resp = RESP_OK;
                        w_alu_data = w_sum[1:DATA_W];
                    end
                end
                CMD_SUB: begin
                    if (u_bus.data <= r_op1) begin
                        w_alu_resp = RESP_OK;
                        w_alu_data = r_op1 - u_bus.data;
                    end
                end
                CMD_SHL: begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = r_op1 << u_bus.data[DATA_W-SHAMT_W:DATA_W-1];
                end
                CMD_SHR: begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = r_op1 >> u_bus.data[DATA_W-SHAMT_W:DATA_W-1];
                end
                default: ;
            endcase
        end

        // Next state: latch cmd/op1 in IDLE, emit the response in OP2
        always_comb begin
            w_state_nxt = r_state;
            w_cmd_nxt   = r_cmd;
            w_op1_nxt   = r_op1;
            w_resp_nxt  = RESP_NONE;
            w_data_nxt  = '0;
            case (r_state)
                ST_IDLE: begin
                    if (u_bus.cmd != CMD_NOP) begin
                        w_cmd_nxt   = u_bus.cmd;
                        w_op1_nxt   = u_bus.data;
                        w_state_nxt = ST_OP2;
                    end
                end
                ST_OP2: begin
                    w_resp_nxt  = w_alu_resp;
                    w_data_nxt  = w_alu_data;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // State, latched operands and response registers
        always_ff @(posedge c_clk) begin
            if (w_rst) begin
                r_state <= ST_IDLE;
                r_cmd   <= '0;
                r_op1   <= '0;
                r_resp  <= RESP_NONE;
                r_data  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cmd   <= w_cmd_nxt;
                r_op1   <= w_op1_nxt;
                r_resp  <= w_resp_nxt;
                r_data  <= w_data_nxt;
            end
        end
    end
endmodule

// File: tb/tb_calc1.sv
// Self-checking bench for calc1: directed table, walking ones, multi-port,
// reset corner cases and randomized traffic against a behavioural model.
module tb_calc1;
    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } res_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    logic       clk;
    logic [1:7] rst;

    logic [0:3]  cmd_a [1:4];
    logic [0:31] dat_a [1:4];
    logic [0:31] dt_a  [1:4];
    logic [0:1]  rs_a  [1:4];

    logic [3:0]  t_cmd [1:4];
    logic [31:0] t_op1 [1:4];
    logic [31:0] t_op2 [1:4];

    int n_vec  = 0;
    int n_miss = 0;

    calc1_if bus1 ();
    calc1_if bus2 ();
    calc1_if bus3 ();
    calc1_if bus4 ();

    assign bus1.cmd = cmd_a[1];
    assign bus2.cmd = cmd_a[2];
    assign bus3.cmd = cmd_a[3];
    assign bus4.cmd = cmd_a[4];
    assign bus1.data = dat_a[1];
    assign bus2.data = dat_a[2];
    assign bus3.data = dat_a[3];
    assign bus4.data = dat_a[4];
    assign dt_a[1] = bus1.out_data;
    assign dt_a[2] = bus2.out_data;
    assign dt_a[3] = bus3.out_data;
    assign dt_a[4] = bus4.out_data;
    assign rs_a[1] = bus1.out_resp;
    assign rs_a[2] = bus2.out_resp;
    assign rs_a[3] = bus3.out_resp;
    assign rs_a[4] = bus4.out_resp;

    calc1 dut (
        .out_data1   (bus1.out_data),
        .out_data2   (bus2.out_data),
        .out_data3   (bus3.out_data),
        .out_data4   (bus4.out_data),
        .out_resp1   (bus1.out_resp),
        .out_resp2   (bus2.out_resp),
        .out_resp3   (bus3.out_resp),
        .out_resp4   (bus4.out_resp),
        .c_clk       (clk),
        .req1_cmd_in (bus1.cmd),
        .req1_data_in(bus1.data),
        .req2_cmd_in (bus2.cmd),
        .req2_data_in(bus2.data),
        .req3_cmd_in (bus3.cmd),
        .req3_data_in(bus3.data),
        .req4_cmd_in (bus4.cmd),
        .req4_data_in(bus4.data),
        .reset       (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on wide integers
    function automatic res_t ref_calc(input logic [3:0] cmd, input logic [31:0] a,
                                      input logic [31:0] b);
        res_t r;
        longint unsigned la;
        longint unsigned lb;
        longint unsigned s;
        int unsigned sh;
        la = 64'(a);
        lb = 64'(b);
        sh = b % 32;
        r.resp = 2'd2;
        r.data = 32'd0;
        case (cmd)
            4'd0: r.resp = 2'd0;
            4'd1: begin
                s = la + lb;
                if (s < 64'h1_0000_0000) begin
                    r.resp = 2'd1;
                    r.data = s[31:0];
                end
            end
            4'd2: begin
                if (lb <= la) begin
                    r.resp = 2'd1;
                    r.data = 32'(la - lb);
                end
            end
            4'd5: begin
                r.resp = 2'd1;
                r.data = 32'((la << sh) & 64'hFFFF_FFFF);
            end
            4'd6: begin
                r.resp = 2'd1;
                r.data = 32'(la >> sh);
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_port(input string name, input int n, input logic [1:0] er,
                              input logic [31:0] ed);
        n_vec++;
        if (rs_a[n] !== er || dt_a[n] !== ed) begin
            n_miss++;
            $display("FAIL %s port%0d: got resp=%0d data=%h, expected resp=%0d data=%h",
                     name, n, rs_a[n], dt_a[n], er, ed);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int n = 1; n <= 4; n++) check_port(name, n, 2'd0, 32'd0);
    endtask

    task automatic clear_req();
        for (int n = 1; n <= 4; n++) begin
            t_cmd[n] = 4'd0;
            t_op1[n] = $urandom;
            t_op2[n] = $urandom;
        end
    endtask

    // Entered at a negedge; returns at the negedge after E2 with cmds idle
    task automatic issue();
        for (int n = 1; n <= 4; n++) begin
            cmd_a[n] = t_cmd[n];
            dat_a[n] = t_op1[n];
        end
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n <= 4; n++) begin
            dat_a[n] = t_op2[n];
            // cmd is ignored in OP2, so scribble on it for busy ports
            cmd_a[n] = (t_cmd[n] != 4'd0) ? 4'($urandom) : 4'd0;
        end
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n <= 4; n++) begin
            cmd_a[n] = 4'd0;
            dat_a[n] = $urandom;
        end
    endtask

    task automatic check_model(input string name);
        res_t e;
        for (int n = 1; n <= 4; n++) begin
            e = ref_calc(t_cmd[n], t_op1[n], t_op2[n]);
            check_port(name, n, e.resp, e.data);
        end
    endtask

    task automatic idle_cycles(input string name, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            for (int n = 1; n <= 4; n++) dat_a[n] = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_all_zero(name);
        end
    endtask

    vec_t tbl [16];
    logic [31:0] one;

    initial begin
        tbl[0]  = '{4'd1,  32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
        tbl[1]  = '{4'd1,  32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE};
        tbl[2]  = '{4'd1,  32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000};
        tbl[3]  = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        tbl[4]  = '{4'd2,  32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0000_0000};
        tbl[5]  = '{4'd3,  32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
        tbl[6]  = '{4'd4,  32'h0000_0010, 32'h0000_0002, 2'd2, 32'h0000_0000};
        tbl[7]  = '{4'd2,  32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000};
        tbl[8]  = '{4'd2,  32'h0000_0010, 32'h0000_0003, 2'd1, 32'h0000_000D};
        tbl[9]  = '{4'd5,  32'h0000_0001, 32'hFFFF_FFE4, 2'd1, 32'h0000_0010};
        tbl[10] = '{4'd6,  32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
        tbl[11] = '{4'd6,  32'hF000_0000, 32'hFFFF_FFE4, 2'd1, 32'h0F00_0000};
        tbl[12] = '{4'd7,  32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        tbl[13] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
        tbl[14] = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};
        tbl[15] = '{4'd5,  32'h8000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002};

        rst = 7'b1000000;
        for (int n = 1; n <= 4; n++) begin
            cmd_a[n] = 4'd0;
            dat_a[n] = $urandom;
        end
        clear_req();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 7'b0000000;
        idle_cycles("idle_nop", 6);

        // Directed table on port 1, other ports idle
        foreach (tbl[i]) begin
            clear_req();
            t_cmd[1] = tbl[i].cmd;
            t_op1[1] = tbl[i].op1;
            t_op2[1] = tbl[i].op2;
            issue();
            check_port($sformatf("tbl%0d", i), 1, tbl[i].resp, tbl[i].data);
            for (int n = 2; n <= 4; n++) check_port("tbl_idle", n, 2'd0, 32'd0);
        end
        idle_cycles("resp_one_cycle", 1);

        // Walking ones through add and both shifts
        for (int k = 0; k <= 30; k++) begin
            clear_req();
            one = 32'd1 << k;
            t_cmd[1] = 4'd1;
            t_op1[1] = one;
            t_op2[1] = 32'd0;
            issue();
            check_port("walk_add", 1, 2'd1, one);
        end
        for (int k = 0; k <= 29; k++) begin
            clear_req();
            t_cmd[1] = 4'd5;
            t_op1[1] = 32'd1 << k;
            t_op2[1] = 32'd1;
            issue();
            one = 32'd1 << (k + 1);
            check_port("walk_shl", 1, 2'd1, one);
        end

        // All four ports complete on the same edge
        clear_req();
        t_cmd[1] = 4'd1; t_op1[1] = 32'd100;   t_op2[1] = 32'd23;
        t_cmd[2] = 4'd2; t_op1[2] = 32'h10;    t_op2[2] = 32'h20;
        t_cmd[3] = 4'd5; t_op1[3] = 32'h3;     t_op2[3] = 32'd4;
        t_cmd[4] = 4'd6; t_op1[4] = 32'h100;   t_op2[4] = 32'd8;
        issue();
        check_port("multi", 1, 2'd1, 32'd123);
        check_port("multi", 2, 2'd2, 32'd0);
        check_port("multi", 3, 2'd1, 32'h30);
        check_port("multi", 4, 2'd1, 32'd1);

        // Reset during OP2 aborts the request
        clear_req();
        for (int n = 1; n <= 4; n++) begin
            cmd_a[n] = 4'd1;
            dat_a[n] = 32'd5;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 7'b1000000;
        for (int n = 1; n <= 4; n++) begin
            cmd_a[n] = 4'd0;
            dat_a[n] = 32'd6;
        end
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_in_op2");
        rst = 7'b0000000;
        idle_cycles("after_abort", 2);
        clear_req();
        t_cmd[1] = 4'd1; t_op1[1] = 32'd7; t_op2[1] = 32'd8;
        issue();
        check_port("post_rst_req", 1, 2'd1, 32'd15);

        // Reset during the response cycle, using a different reset bit
        clear_req();
        t_cmd[2] = 4'd2; t_op1[2] = 32'd9; t_op2[2] = 32'd4;
        issue();
        check_port("pre_rst_resp", 2, 2'd1, 32'd5);
        rst = 7'b0000001;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_in_resp");

        // Requests presented while reset is held never start
        for (int n = 1; n <= 4; n++) cmd_a[n] = 4'd1;
        idle_cycles("rst_held", 3);
        for (int n = 1; n <= 4; n++) cmd_a[n] = 4'd0;
        rst = 7'b0000000;
        idle_cycles("rst_release", 2);

        // Randomized back-to-back traffic on all ports against the model
        for (int it = 0; it < 150; it++) begin
            for (int n = 1; n <= 4; n++) begin
                case ($urandom_range(0, 9))
                    0: t_cmd[n] = 4'd0;
                    1, 2: t_cmd[n] = 4'd1;
                    3, 4: t_cmd[n] = 4'd2;
                    5: t_cmd[n] = 4'd5;
                    6: t_cmd[n] = 4'd6;
                    7: t_cmd[n] = 4'd3;
                    8: t_cmd[n] = 4'd4;
                    default: t_cmd[n] = 4'($urandom_range(7, 15));
                endcase
                t_op1[n] = $urandom;
                case ($urandom_range(0, 3))
                    0: t_op2[n] = t_op1[n];
                    1: t_op2[n] = 32'($urandom_range(0, 40));
                    default: t_op2[n] = $urandom;
                endcase
            end
            issue();
            check_model($sformatf("rand%0d", it));
            if (it % 25 == 24) idle_cycles("rand_gap", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/calc1.md
# calc1

Four-port 32-bit integer calculator. Each port independently accepts a two-cycle request (command plus operand 1, then operand 2). Each port returns a one-cycle response code with the result on its own output pair. It is a standalone leaf block; requesters drive ports 1–4 and sample the per-port response outputs.

## Interface
- No parameters. Data width is fixed at 32 bits, command width at 4, response width at 2. Bit 0 is the MSB of every bus, e.g. data [0:31].
- c_clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, [1:7]: synchronous, active-high. Any bit high resets the whole block; driving reset[1] alone is sufficient.
- reqN_cmd_in, input, [0:3], N=1..4: command for port N, sampled in the first request cycle.
- reqN_data_in, input, [0:31], N=1..4: operand 1 in the first cycle, operand 2 in the second cycle.
- out_dataN, output, [0:31], N=1..4: result for port N.
- out_respN, output, [0:1], N=1..4: response code for port N.
- Port order in the module header: out_data1..4, out_resp1..4, c_clk, then req1_cmd_in, req1_data_in … req4_cmd_in, req4_data_in, then reset.

## Operation
- Commands:
  - 0 = no-op.
  - 1 = add.
  - 2 = subtract (op1 − op2).
  - 5 = shift left op1 by op2[27:31].
  - 6 = shift right (logical) op1 by op2[27:31].
  - 3, 4, 7–15 = invalid.
- Response codes:
  - 0 = no response.
  - 1 = success.
  - 2 = overflow, underflow or invalid command.
  - 3 = reserved, never driven.
- Add is unsigned 32-bit. A carry out of bit 0 gives resp 2, data 0.
- Subtract is unsigned. op2 > op1 gives resp 2, data 0. op1 == op2 gives resp 1, data 0.
- Shifts:
  - Bits shifted out are discarded and vacated bits fill with 0. The result is always resp 1.
  - Upper operand-2 bits [0:26] are ignored.
- Invalid command:
  - Still consumes the operand-2 cycle.
  - Gives resp 2, data 0.
- out_dataN is 0 whenever out_respN is 0 or 2.
- Ports are fully independent: separate state machines and ALUs, with no arbitration or shared resources. All four may complete in the same cycle.
- Per-port FSM:
  - IDLE: when cmd ≠ 0 is sampled, latch cmd and op1, then go to OP2. When cmd = 0 is sampled, stay in IDLE; reqN_data_in is ignored.
  - OP2: sample reqN_data_in as op2, compute, register the response, then go to IDLE. reqN_cmd_in is ignored in this cycle.

## Timing
- Reset:
  - All outputs are 0 after the first rising edge with reset asserted.
  - All FSMs go to IDLE and latched operands clear.
  - Outputs stay 0 while reset is held.
- Request:
  - Edge E1 samples cmd and op1.
  - Edge E2 samples op2.
  - The requester holds each value stable across its sampling edge.
- Latency:
  - out_respN and out_dataN are registered at E2.
  - They are valid for exactly one cycle, E2 to E3.
  - They return to 0 at E3 unless E3 itself completes another request.
- Throughput: a new command may be presented at E3, giving back-to-back requests every 2 cycles per port.
- Reset during OP2 aborts the request; no response is ever produced for it.
- Reset during the response cycle clears outputs at the next edge.
- Simultaneous requests on all four ports complete on the same edge with independent results.

## Test plan
- Reset, then all cmd = 0 with random data on all ports for several cycles → every out_respN = 0 and out_dataN = 0.
- Port 1 add, op1 = 0x00000001, op2 = 0x1FFFFFFF → resp 1, data 0x20000000, one cycle after E2. Also op1 = op2 = 0x1FFFFFFF → 0x3FFFFFFE. Also 0 + 0 → resp 1, data 0.
- Error cases on port 1:
  - Add 0xFFFFFFFF + 1 → resp 2, data 0.
  - Subtract 1 − 0xF → resp 2, data 0.
  - cmd 3 and cmd 4 → resp 2, data 0.
- Walking-ones check on port 1:
  - Add 1<<k + 0 for k = 0..30 → resp 1, data 1<<k.
  - Shift-left 1<<k by 1 for k = 0..29 → data 1<<(k+1).
  - Shift-right 0x80000000 by 31 → data 1.
- All four ports issue different commands on the same edges → each port returns its own correct result in the same cycle. Follow with back-to-back requests at a 2-cycle spacing → no dropped or merged responses.
- Assert reset[1] during OP2 → no response for that request, all outputs 0. The next request after reset completes normally.
